// File: rtl/ppm_pkg.sv
// Shared types and default timing constants for the PPM capture core.
package ppm_pkg;

  typedef enum logic {WAIT_SYNC, CAPTURE} ppm_state_t;

  localparam int PPM_MIN_WIDTH = 50000;
  localparam int PPM_SYNC_MIN  = 400000;
  localparam int PPM_TIMEOUT   = 1000000;
  localparam int ERR_CNT_W     = 8;
  localparam int FRAME_CNT_W   = 16;

endpackage

// File: rtl/ppm_in_sync.sv
// Brings the asynchronous PPM pin into the clock domain and emits a
// registered one-cycle pulse on each synchronised rising edge.
module ppm_in_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ppm_in,
  output logic edge_evt
);

  logic sync_p0, sync_p1, prev_p2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0  <= 1'b0;
      sync_p1  <= 1'b0;
      prev_p2  <= 1'b0;
      edge_evt <= 1'b0;
    end else begin
      // p0/p1: metastability filter; p2: previous level for edge detect
      sync_p0  <= ppm_in;
      sync_p1  <= sync_p0;
      prev_p2  <= sync_p1;
      edge_evt <= sync_p1 & ~prev_p2;
    end
  end

endmodule

// File: rtl/ppm_capture.sv
// PPM frame capture: interval counter, sync/channel FSM and atomic
// commit of a full frame of channel widths with status counters.
module ppm_capture
  import ppm_pkg::*;
#(
  parameter int NUM_CH    = 6,
  parameter int CNT_W     = 20,
  parameter int MIN_WIDTH = PPM_MIN_WIDTH,
  parameter int SYNC_MIN  = PPM_SYNC_MIN,
  parameter int TIMEOUT   = PPM_TIMEOUT
) (
  input  logic                    s00_axi_aclk,
  input  logic                    s00_axi_aresetn,
  input  logic                    capture_en,
  input  logic                    ppm_in,
  output logic [NUM_CH*CNT_W-1:0] ch_width_o,
  output logic                    frame_valid_o,
  output logic [FRAME_CNT_W-1:0]  frame_cnt_o,
  output logic [ERR_CNT_W-1:0]    err_cnt_o,
  output logic                    signal_lost_o
);

  localparam int IDX_W = $clog2(NUM_CH + 1);
  localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_WIDTH);
  localparam logic [CNT_W-1:0] SYNC_C   = CNT_W'(SYNC_MIN);
  localparam logic [CNT_W-1:0] TO_C     = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_M1    = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH);

  function automatic logic [ERR_CNT_W-1:0] sat_inc_err(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic             edge_evt;
  logic [CNT_W-1:0] cnt;
  ppm_state_t       state, state_nx;
  logic [IDX_W-1:0] ch_idx, idx_nx;
  logic [CNT_W-1:0] shadow [NUM_CH];
  logic             timeout_hit, is_sync, store, commit, err_inc, lost_set;

  ppm_in_sync u_sync (
    .clk      (s00_axi_aclk),
    .rst_n    (s00_axi_aresetn),
    .ppm_in   (ppm_in),
    .edge_evt (edge_evt)
  );

  // cnt about to reach TIMEOUT; a coincident edge takes priority
  assign timeout_hit = (cnt == TO_M1) && !edge_evt;
  assign is_sync     = (cnt >= SYNC_C);
  assign lost_set    = capture_en && timeout_hit;

  always_comb begin
    state_nx = state;
    idx_nx   = ch_idx;
    store    = 1'b0;
    commit   = 1'b0;
    err_inc  = 1'b0;
    if (!capture_en) begin
      state_nx = WAIT_SYNC;
      idx_nx   = '0;
    end else if (edge_evt) begin
      if (state == WAIT_SYNC) begin
        if (is_sync) begin
          state_nx = CAPTURE;
          idx_nx   = '0;
        end
      end else if (cnt < MIN_C) begin
        err_inc  = 1'b1;
        state_nx = WAIT_SYNC;
        idx_nx   = '0;
      end else if (!is_sync) begin
        if (ch_idx < LAST_IDX) begin
          store  = 1'b1;
          idx_nx = ch_idx + 1'b1;
        end else begin
          err_inc  = 1'b1;
          state_nx = WAIT_SYNC;
          idx_nx   = '0;
        end
      end else begin
        // a sync gap always restarts the frame; only a full one commits
        commit  = (ch_idx == LAST_IDX);
        err_inc = (ch_idx != LAST_IDX);
        idx_nx  = '0;
      end
    end else if (timeout_hit) begin
      err_inc  = (state == CAPTURE);
      state_nx = WAIT_SYNC;
      idx_nx   = '0;
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      cnt           <= '0;
      state         <= WAIT_SYNC;
      ch_idx        <= '0;
      ch_width_o    <= '0;
      frame_valid_o <= 1'b0;
      frame_cnt_o   <= '0;
      err_cnt_o     <= '0;
      signal_lost_o <= 1'b1;
    end else begin
      if (edge_evt)         cnt <= CNT_W'(1);
      else if (cnt != TO_C) cnt <= cnt + 1'b1;
      state         <= state_nx;
      ch_idx        <= idx_nx;
      frame_valid_o <= commit;
      if (commit) begin
        for (int i = 0; i < NUM_CH; i++) ch_width_o[i*CNT_W +: CNT_W] <= shadow[i];
        frame_cnt_o   <= frame_cnt_o + 1'b1;
        signal_lost_o <= 1'b0;
      end else if (lost_set) begin
        signal_lost_o <= 1'b1;
      end
      if (err_inc) err_cnt_o <= sat_inc_err(err_cnt_o);
    end
  end

  // shadow holds the frame being assembled; it needs no reset
  always_ff @(posedge s00_axi_aclk) begin
    if (store) begin
      for (int i = 0; i < NUM_CH; i++)
        if (ch_idx == IDX_W'(i)) shadow[i] <= cnt;
    end
  end

endmodule

// File: tb/tb_ppm_capture.sv
// Scenario bench for ppm_capture: expected frames are queued as stimulus is
// driven and matched against strobed frames captured from the DUT.
module tb_ppm_capture;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 12;
  localparam int W      = NUM_CH * CNT_W;

  typedef struct { logic [W-1:0] w; int t; } ev_t;

  logic clk = 1'b0;
  logic rst_n, capture_en, ppm_in, ppm_sat;
  logic [W-1:0] ch_width, ch_width_sat;
  logic fv, fv_sat, lost, lost_sat;
  logic [15:0] fcnt, fcnt_sat;
  logic [7:0] err, err_sat;

  int cyc = 0;
  int n_vec = 0;
  int n_miss = 0;
  ev_t sb[$];
  ev_t ob[$];
  bit pend_ok = 1'b0;
  logic [W-1:0] pend_w = '0;

  ppm_capture #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .MIN_WIDTH(50), .SYNC_MIN(400), .TIMEOUT(1000)) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n), .capture_en(capture_en), .ppm_in(ppm_in),
    .ch_width_o(ch_width), .frame_valid_o(fv), .frame_cnt_o(fcnt), .err_cnt_o(err),
    .signal_lost_o(lost));

  ppm_capture #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .MIN_WIDTH(4), .SYNC_MIN(8), .TIMEOUT(64)) u_sat (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n), .capture_en(capture_en), .ppm_in(ppm_sat),
    .ch_width_o(ch_width_sat), .frame_valid_o(fv_sat), .frame_cnt_o(fcnt_sat),
    .err_cnt_o(err_sat), .signal_lost_o(lost_sat));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (fv) ob.push_back('{ch_width, cyc});

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Rising edge now, then low until the next edge `gap` cycles later.
  task automatic rise(input int gap);
    if (pend_ok) begin
      sb.push_back('{pend_w, cyc + 4});
      pend_ok = 1'b0;
    end
    ppm_in = 1'b1;
    repeat (5) step();
    ppm_in = 1'b0;
    repeat (gap - 5) step();
  endtask

  // Sync-terminating edge, n channel intervals, then a 500-cycle sync gap.
  task automatic frame(input int n, input int g0, input int g1, input int g2, input int g3);
    int g[4];
    g = '{g0, g1, g2, g3};
    for (int i = 0; i < n; i++) rise(g[i]);
    rise(500);
    pend_ok = (n == NUM_CH);
    pend_w  = {CNT_W'(g3), CNT_W'(g2), CNT_W'(g1), CNT_W'(g0)};
  endtask

  // Commit edge for the pending frame, then park in WAIT_SYNC via capture_en.
  task automatic close_frame();
    rise(20);
    capture_en = 1'b0;
    repeat (20) step();
    capture_en = 1'b1;
    repeat (460) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; capture_en = 1'b1; ppm_in = 1'b0; ppm_sat = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    n_vec++; if (ch_width !== '0) begin n_miss++; $display("FAIL reset_width got %h want 0", ch_width); end
    n_vec++; if (fv !== 1'b0) begin n_miss++; $display("FAIL reset_valid got %b want 0", fv); end
    n_vec++; if (fcnt !== 16'd0) begin n_miss++; $display("FAIL reset_fcnt got %0d want 0", fcnt); end
    n_vec++; if (err !== 8'd0) begin n_miss++; $display("FAIL reset_err got %0d want 0", err); end
    n_vec++; if (lost !== 1'b1) begin n_miss++; $display("FAIL reset_lost got %b want 1", lost); end
  endtask

  task automatic test_idle();
    repeat (2000) step();
    n_vec++; if (ch_width !== '0 || fcnt !== 16'd0 || err !== 8'd0) begin
      n_miss++; $display("FAIL idle_outputs got w=%h f=%0d e=%0d want 0/0/0", ch_width, fcnt, err);
    end
    n_vec++; if (lost !== 1'b1) begin n_miss++; $display("FAIL idle_lost got %b want 1", lost); end
    n_vec++; if (ob.size() != 0) begin n_miss++; $display("FAIL idle_strobes got %0d want 0", ob.size()); end
  endtask

  task automatic test_clean_frames();
    ev_t e, o;
    frame(4, 100, 150, 200, 250);
    frame(4, 100, 150, 200, 250);
    n_vec++; if (fcnt !== 16'd1) begin n_miss++; $display("FAIL clean_fcnt1 got %0d want 1", fcnt); end
    n_vec++; if (lost !== 1'b0) begin n_miss++; $display("FAIL clean_lost got %b want 0", lost); end
    frame(4, 100, 150, 200, 250);
    close_frame();
    n_vec++; if (fcnt !== 16'd3) begin n_miss++; $display("FAIL clean_fcnt3 got %0d want 3", fcnt); end
    n_vec++; if (err !== 8'd0) begin n_miss++; $display("FAIL clean_err got %0d want 0", err); end
    while (sb.size() > 0 && ob.size() > 0) begin
      e = sb.pop_front(); o = ob.pop_front();
      n_vec++; if (o.w !== e.w || o.t != e.t) begin
        n_miss++; $display("FAIL clean_frame got %h@%0d want %h@%0d", o.w, o.t, e.w, e.t);
      end
    end
    n_vec++; if (sb.size() != 0 || ob.size() != 0) begin
      n_miss++; $display("FAIL clean_count missing=%0d extra=%0d want 0/0", sb.size(), ob.size());
    end
    sb.delete(); ob.delete();
  endtask

  task automatic test_short_frame();
    ev_t e, o;
    logic [7:0] e0; logic [15:0] f0; logic [W-1:0] prev;
    e0 = err; f0 = fcnt; prev = ch_width;
    frame(3, 100, 150, 200, 0);
    frame(4, 110, 120, 130, 140);
    n_vec++; if (err !== e0 + 8'd1) begin n_miss++; $display("FAIL short_err got %0d want %0d", err, e0 + 8'd1); end
    n_vec++; if (ch_width !== prev) begin n_miss++; $display("FAIL short_hold got %h want %h", ch_width, prev); end
    n_vec++; if (fcnt !== f0) begin n_miss++; $display("FAIL short_fcnt got %0d want %0d", fcnt, f0); end
    close_frame();
    n_vec++; if (fcnt !== f0 + 16'd1) begin n_miss++; $display("FAIL short_next_fcnt got %0d want %0d", fcnt, f0 + 16'd1); end
    while (sb.size() > 0 && ob.size() > 0) begin
      e = sb.pop_front(); o = ob.pop_front();
      n_vec++; if (o.w !== e.w || o.t != e.t) begin
        n_miss++; $display("FAIL short_frame got %h@%0d want %h@%0d", o.w, o.t, e.w, e.t);
      end
    end
    n_vec++; if (sb.size() != 0 || ob.size() != 0) begin
      n_miss++; $display("FAIL short_count missing=%0d extra=%0d want 0/0", sb.size(), ob.size());
    end
    sb.delete(); ob.delete();
  endtask

  task automatic test_glitch();
    ev_t e, o;
    logic [7:0] e0; logic [15:0] f0; logic [W-1:0] prev;
    e0 = err; f0 = fcnt; prev = ch_width;
    rise(100);
    rise(20);
    rise(500);
    frame(4, 60, 70, 80, 90);
    n_vec++; if (err !== e0 + 8'd1) begin n_miss++; $display("FAIL glitch_err got %0d want %0d", err, e0 + 8'd1); end
    n_vec++; if (fcnt !== f0 || ch_width !== prev) begin
      n_miss++; $display("FAIL glitch_nocommit got f=%0d w=%h want f=%0d w=%h", fcnt, ch_width, f0, prev);
    end
    close_frame();
    while (sb.size() > 0 && ob.size() > 0) begin
      e = sb.pop_front(); o = ob.pop_front();
      n_vec++; if (o.w !== e.w || o.t != e.t) begin
        n_miss++; $display("FAIL glitch_frame got %h@%0d want %h@%0d", o.w, o.t, e.w, e.t);
      end
    end
    n_vec++; if (sb.size() != 0 || ob.size() != 0) begin
      n_miss++; $display("FAIL glitch_count missing=%0d extra=%0d want 0/0", sb.size(), ob.size());
    end
    sb.delete(); ob.delete();
  endtask

  task automatic test_timeout();
    ev_t e, o;
    logic [7:0] e0; logic [15:0] f0; int t0;
    e0 = err; f0 = fcnt;
    rise(100);
    rise(150);
    t0 = cyc;
    ppm_in = 1'b1;
    repeat (5) step();
    ppm_in = 1'b0;
    while (cyc < t0 + 1001) step();
    n_vec++; if (lost !== 1'b0) begin n_miss++; $display("FAIL timeout_early got %b want 0", lost); end
    while (cyc < t0 + 1004) step();
    n_vec++; if (lost !== 1'b1) begin n_miss++; $display("FAIL timeout_lost got %b want 1", lost); end
    while (cyc < t0 + 1200) step();
    n_vec++; if (err !== e0 + 8'd1) begin n_miss++; $display("FAIL timeout_err got %0d want %0d", err, e0 + 8'd1); end
    frame(4, 100, 150, 200, 250);
    n_vec++; if (lost !== 1'b1) begin n_miss++; $display("FAIL timeout_hold got %b want 1", lost); end
    frame(4, 300, 250, 200, 150);
    n_vec++; if (lost !== 1'b0 || fcnt !== f0 + 16'd1) begin
      n_miss++; $display("FAIL timeout_resume got lost=%b f=%0d want 0/%0d", lost, fcnt, f0 + 16'd1);
    end
    close_frame();
    n_vec++; if (err !== e0 + 8'd1) begin n_miss++; $display("FAIL timeout_err_once got %0d want %0d", err, e0 + 8'd1); end
    while (sb.size() > 0 && ob.size() > 0) begin
      e = sb.pop_front(); o = ob.pop_front();
      n_vec++; if (o.w !== e.w || o.t != e.t) begin
        n_miss++; $display("FAIL timeout_frame got %h@%0d want %h@%0d", o.w, o.t, e.w, e.t);
      end
    end
    n_vec++; if (sb.size() != 0 || ob.size() != 0) begin
      n_miss++; $display("FAIL timeout_count missing=%0d extra=%0d want 0/0", sb.size(), ob.size());
    end
    sb.delete(); ob.delete();
  endtask

  task automatic test_control();
    ev_t e, o;
    logic [7:0] e0; logic [15:0] f0; logic [W-1:0] prev;
    e0 = err; f0 = fcnt; prev = ch_width;
    rise(100);
    rise(150);
    ppm_in = 1'b1; repeat (5) step(); ppm_in = 1'b0;
    repeat (20) step();
    capture_en = 1'b0;
    repeat (30) step();
    capture_en = 1'b1;
    repeat (145) step();
    rise(250);
    rise(500);
    frame(4, 60, 70, 80, 90);
    n_vec++; if (err !== e0 || fcnt !== f0 || ch_width !== prev) begin
      n_miss++; $display("FAIL disable_hold got e=%0d f=%0d w=%h want %0d/%0d/%h", err, fcnt, ch_width, e0, f0, prev);
    end
    close_frame();
    n_vec++; if (fcnt !== f0 + 16'd1) begin n_miss++; $display("FAIL disable_resume got %0d want %0d", fcnt, f0 + 16'd1); end
    // reset pulse in the middle of a frame
    rise(100);
    rise(150);
    ppm_in = 1'b1; repeat (5) step(); ppm_in = 1'b0;
    repeat (50) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_vec++; if (ch_width !== '0 || fv !== 1'b0 || fcnt !== 16'd0 || err !== 8'd0 || lost !== 1'b1) begin
      n_miss++; $display("FAIL midreset got w=%h v=%b f=%0d e=%0d l=%b want 0/0/0/0/1", ch_width, fv, fcnt, err, lost);
    end
    repeat (144) step();
    rise(250);
    rise(500);
    frame(4, 80, 90, 100, 110);
    close_frame();
    n_vec++; if (fcnt !== 16'd1 || err !== 8'd0 || lost !== 1'b0) begin
      n_miss++; $display("FAIL postreset got f=%0d e=%0d l=%b want 1/0/0", fcnt, err, lost);
    end
    while (sb.size() > 0 && ob.size() > 0) begin
      e = sb.pop_front(); o = ob.pop_front();
      n_vec++; if (o.w !== e.w || o.t != e.t) begin
        n_miss++; $display("FAIL control_frame got %h@%0d want %h@%0d", o.w, o.t, e.w, e.t);
      end
    end
    n_vec++; if (sb.size() != 0 || ob.size() != 0) begin
      n_miss++; $display("FAIL control_count missing=%0d extra=%0d want 0/0", sb.size(), ob.size());
    end
    sb.delete(); ob.delete();
  endtask

  // Short timing on a second instance so 300 short-frame errors fit quickly.
  task automatic test_err_saturation();
    n_vec++; if (err_sat !== 8'd0) begin n_miss++; $display("FAIL sat_start got %0d want 0", err_sat); end
    for (int i = 0; i < 301; i++) begin
      ppm_sat = 1'b1; repeat (5) step();
      ppm_sat = 1'b0; repeat (5) step();
      if (i == 100) begin
        n_vec++; if (err_sat !== 8'd100) begin n_miss++; $display("FAIL sat_mid got %0d want 100", err_sat); end
      end
    end
    repeat (10) step();
    n_vec++; if (err_sat !== 8'd255) begin n_miss++; $display("FAIL sat_err got %0d want 255", err_sat); end
    n_vec++; if (fcnt_sat !== 16'd0 || ch_width_sat !== '0 || fv_sat !== 1'b0 || lost_sat !== 1'b1) begin
      n_miss++; $display("FAIL sat_outputs got f=%0d w=%h v=%b l=%b want 0/0/0/1", fcnt_sat, ch_width_sat, fv_sat, lost_sat);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_clean_frames();
    test_short_frame();
    test_glitch();
    test_timeout();
    test_control();
    test_err_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
